midi_msg_tx: RTL

- Message-level MIDI transmitter: the sending counterpart of the synth's MIDI receiver/status logger.
- Accepts one complete MIDI message per handshake (status plus up to two data bytes).
- Works out the message length from the status byte and applies running-status compression.
- Serialises the resulting bytes at 31250 baud (8N1, LSB first) on the MIDI TX pin. It is used for MIDI thru/echo and for controller feedback to external gear.

---
 rtl/midi_msg_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/midi_msg_tx.sv
// Message-level MIDI transmitter: decodes message length, applies running-status
// compression and serialises the bytes as 8N1 frames, LSB first.
module midi_msg_tx #(
    parameter int CLK_DIV    = 800,
    parameter int RS_TIMEOUT = 25000000
) (
    input  logic       CLOCK_25,
    input  logic       reset_reg_N,
    input  logic       msg_valid,
    output logic       msg_ready,
    input  logic [7:0] msg_status,
    input  logic [7:0] msg_data1,
    input  logic [7:0] msg_data2,
    input  logic       rs_enable,
    output logic       midi_txd,
    output logic       busy,
    output logic       byte_sent,
    output logic       rs_skipped,
    output logic       msg_error
);

    localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (RS_TIMEOUT > 1) ? $clog2(RS_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [1:0]      bytes_left;
    logic [23:0]     tx_buf;
    logic [7:0]      rs_status;
    logic            rs_held;
    logic [TW-1:0]   idle_cnt;

    logic            accept;
    logic            go;
    logic            is_channel;
    logic            timeout_now;
    logic            rs_live;
    logic            skip;
    logic            bit_last;
    logic [1:0]      msg_len;
    logic [7:0]      data1_b;
    logic [7:0]      data2_b;
    logic            unused_bits;

    assign unused_bits = msg_data1[7] ^ msg_data2[7];

    assign msg_ready   = (state == IDLE);
    assign busy        = ~msg_ready;
    assign accept      = msg_valid && msg_ready;
    assign go          = accept && msg_status[7];
    assign msg_error   = accept && !msg_status[7];
    assign is_channel  = msg_status[7] && (msg_status[7:4] != 4'hF);
    assign timeout_now = (RS_TIMEOUT != 0) && (idle_cnt == TW'(RS_TIMEOUT));
    // A timeout reached in the acceptance cycle already hides the held status.
    assign rs_live     = rs_held && !timeout_now;
    assign skip        = go && is_channel && rs_enable && rs_live && (msg_status == rs_status);
    assign rs_skipped  = skip;
    assign bit_last    = (bit_cnt == BW'(CLK_DIV - 1));
    assign byte_sent   = (state == STOP) && bit_last;
    assign data1_b     = {1'b0, msg_data1[6:0]};
    assign data2_b     = {1'b0, msg_data2[6:0]};

    always_comb begin
        msg_len = 2'd1;
        if (msg_status[7:4] == 4'hC || msg_status[7:4] == 4'hD) begin
            msg_len = 2'd2;
        end else if (msg_status[7:4] != 4'hF) begin
            msg_len = 2'd3;
        end else if (msg_status[3:0] == 4'h1 || msg_status[3:0] == 4'h3) begin
            msg_len = 2'd2;
        end else if (msg_status[3:0] == 4'h2) begin
            msg_len = 2'd3;
        end
    end

    always_comb begin
        midi_txd = 1'b1;
        case (state)
            START:   midi_txd = 1'b0;
            DATA:    midi_txd = tx_buf[bit_idx];
            default: midi_txd = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = START;
            START:   if (bit_last) state_nxt = DATA;
            DATA:    if (bit_last && bit_idx == 3'd7) state_nxt = STOP;
            STOP:    if (bit_last) state_nxt = (bytes_left > 2'd1) ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_25 or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            bit_cnt    <= '0;
            bit_idx    <= 3'd0;
            bytes_left <= 2'd0;
            tx_buf     <= 24'h0;
            rs_status  <= 8'h00;
            rs_held    <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            if (state == IDLE || bit_last) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (state != DATA) begin
                bit_idx <= 3'd0;
            end else if (bit_last) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (go) begin
                if (skip) begin
                    tx_buf     <= {8'h00, data2_b, data1_b};
                    bytes_left <= msg_len - 2'd1;
                end else begin
                    tx_buf     <= {data2_b, data1_b, msg_status};
                    bytes_left <= msg_len;
                end
            end else if (state == STOP && bit_last) begin
                tx_buf     <= {8'h00, tx_buf[23:8]};
                bytes_left <= bytes_left - 2'd1;
            end

            if (timeout_now) begin
                rs_held <= 1'b0;
            end
            // Real-time bytes (0xF8-0xFF, bit3 set) leave running status alone.
            if (go) begin
                if (is_channel) begin
                    rs_held   <= 1'b1;
                    rs_status <= msg_status;
                end else if (!msg_status[3]) begin
                    rs_held <= 1'b0;
                end
            end

            if (go) begin
                idle_cnt <= '0;
            end else if (state == IDLE && RS_TIMEOUT != 0 && !timeout_now) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule
